// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage: icodes, status codes, fetch states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Largest legal ifun for the icodes that carry a function code.
  localparam logic [3:0] MAXFN_RRMOVQ = 4'd6;
  localparam logic [3:0] MAXFN_OPQ    = 4'd3;
  localparam logic [3:0] MAXFN_JXX    = 4'd6;

  typedef enum logic [2:0] {
    F_OP    = 3'd0,
    F_REG   = 3'd1,
    F_CONST = 3'd2,
    OUT     = 3'd3,
    STOP    = 3'd4
  } fetch_state_t;

  function automatic logic [3:0] max_ifun(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ: max_ifun = MAXFN_RRMOVQ;
      I_OPQ:    max_ifun = MAXFN_OPQ;
      I_JXX:    max_ifun = MAXFN_JXX;
      default:  max_ifun = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_fetch_unit_if.sv
// Bundle between fetch and its neighbours: byte memory port, redirect, decode handshake.
// Latency: n/a (wires only).
// Backpressure: decode stalls fetch via out_ready; memory stalls via mem_ack.
// Modports: master = fetch unit, slave = memory/decode/redirect environment.
interface y86_fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              mem_err;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic [ADDR_W-1:0] pc_out;
  logic [1:0]        stat;

  modport master (
    output mem_req, mem_addr, out_valid, icode, ifun, ra, rb, valC, valP, pc_out, stat,
    input  mem_ack, mem_rdata, mem_err, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, icode, ifun, ra, rb, valC, valP, pc_out, stat,
    output mem_ack, mem_rdata, mem_err, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/y86_instr_len.sv
// Classifies an opcode byte: register byte / constant presence, length, legality.
// Latency: combinational.
// Backpressure: none.
// Ports: icode/ifun in; need_reg, need_valC, length[3:0], instr_valid out.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       need_reg,
  output logic       need_valC,
  output logic [3:0] length,
  output logic       instr_valid
);

  always_comb begin
    need_reg    = 1'b0;
    need_valC   = 1'b0;
    length      = 4'd1;
    instr_valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: length = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        need_reg = 1'b1;
        length   = 4'd2;
      end
      I_JXX, I_CALL: begin
        need_valC = 1'b1;
        length    = 4'd9;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_reg  = 1'b1;
        need_valC = 1'b1;
        length    = 4'd10;
      end
      default: instr_valid = 1'b0;
    endcase
    if (ifun > max_ifun(icode)) instr_valid = 1'b0;
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch: reads instruction bytes serially from PC and hands decoded fields to decode.
// Latency: N-byte instruction valid N cycles after first request (zero-wait), N+1 cycles/instr.
// Backpressure: holds all outputs stable in OUT until out_ready; memory waits stall per byte.
// Ports: clk, rst_n (async active-low); bus = y86_fetch_unit_if.master (memory, redirect, decode).
// Optional: define STRICT_REG_CHECK_EN to flag illegal register-byte fields as INS.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  y86_fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        idx_q, idx_d;
  logic [2:0]        cidx_q, cidx_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic [1:0]        stat_q, stat_d;

  logic              fetching;
  logic              mem_req;
  logic              take;
  logic [3:0]        dec_icode, dec_ifun;
  logic              need_reg, need_valc, instr_valid;
  logic [3:0]        len;

  // The opcode byte is classified as it arrives; later states use the stored icode.
  assign dec_icode = (state_q == F_OP) ? bus.mem_rdata[7:4] : icode_q;
  assign dec_ifun  = (state_q == F_OP) ? bus.mem_rdata[3:0] : ifun_q;

  y86_instr_len u_len (
    .icode       (dec_icode),
    .ifun        (dec_ifun),
    .need_reg    (need_reg),
    .need_valC   (need_valc),
    .length      (len),
    .instr_valid (instr_valid)
  );

`ifdef STRICT_REG_CHECK_EN
  // Fields an instruction ignores must be F; fields it uses must name a register.
  function automatic logic reg_fields_ok(input logic [3:0] ic, input logic [3:0] a,
                                         input logic [3:0] b);
    case (ic)
      I_RRMOVQ, I_OPQ, I_RMMOVQ, I_MRMOVQ: reg_fields_ok = (a != REG_NONE) && (b != REG_NONE);
      I_IRMOVQ:                            reg_fields_ok = (a == REG_NONE) && (b != REG_NONE);
      I_PUSHQ, I_POPQ:                     reg_fields_ok = (a != REG_NONE) && (b == REG_NONE);
      default:                             reg_fields_ok = 1'b1;
    endcase
  endfunction
`endif

  // run_q keeps mem_req low during reset and lets it rise on the first cycle after release.
  assign fetching = (state_q == F_OP) || (state_q == F_REG) || (state_q == F_CONST);
  assign mem_req  = run_q && fetching;
  assign take     = mem_req && bus.mem_ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    cidx_d  = cidx_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;

    if (bus.redirect_valid) begin
      // Wins over a same-cycle byte (dropped) and over an OUT handshake (consumed).
      pc_d    = bus.redirect_pc;
      idx_d   = 4'd0;
      state_d = F_OP;
    end else begin
      case (state_q)
        F_OP: begin
          if (take) begin
            idx_d  = idx_q + 4'd1;
            ra_d   = REG_NONE;
            rb_d   = REG_NONE;
            valc_d = 64'd0;
            valp_d = pc_q + ADDR_W'(len);
            stat_d = STAT_AOK;
            if (bus.mem_err) begin
              icode_d = I_NOP;
              ifun_d  = 4'd0;
              stat_d  = STAT_ADR;
              state_d = OUT;
            end else begin
              icode_d = bus.mem_rdata[7:4];
              ifun_d  = bus.mem_rdata[3:0];
              if (!instr_valid) begin
                stat_d  = STAT_INS;
                state_d = OUT;
              end else if (dec_icode == I_HALT) begin
                stat_d  = STAT_HLT;
                state_d = OUT;
              end else if (need_reg) begin
                state_d = F_REG;
              end else if (need_valc) begin
                cidx_d  = 3'd0;
                state_d = F_CONST;
              end else begin
                state_d = OUT;
              end
            end
          end
        end
        F_REG: begin
          if (take) begin
            idx_d = idx_q + 4'd1;
            if (bus.mem_err) begin
              stat_d  = STAT_ADR;
              state_d = OUT;
            end else begin
              ra_d = bus.mem_rdata[7:4];
              rb_d = bus.mem_rdata[3:0];
`ifdef STRICT_REG_CHECK_EN
              if (!reg_fields_ok(icode_q, bus.mem_rdata[7:4], bus.mem_rdata[3:0])) begin
                stat_d  = STAT_INS;
                state_d = OUT;
              end else
`endif
              if (need_valc) begin
                cidx_d  = 3'd0;
                state_d = F_CONST;
              end else begin
                state_d = OUT;
              end
            end
          end
        end
        F_CONST: begin
          if (take) begin
            idx_d = idx_q + 4'd1;
            if (bus.mem_err) begin
              stat_d  = STAT_ADR;
              state_d = OUT;
            end else begin
              // Little-endian: constant byte k lands in valC[8k+7:8k].
              valc_d[{cidx_q, 3'b000} +: 8] = bus.mem_rdata;
              cidx_d = cidx_q + 3'd1;
              if (cidx_q == 3'd7) state_d = OUT;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (stat_q == STAT_AOK) begin
              pc_d    = valp_q;
              idx_d   = 4'd0;
              state_d = F_OP;
            end else begin
              state_d = STOP;
            end
          end
        end
        STOP: state_d = STOP;
        default: state_d = F_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_OP;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      idx_q   <= 4'd0;
      cidx_q  <= 3'd0;
      icode_q <= I_NOP;
      ifun_q  <= 4'd0;
      ra_q    <= REG_NONE;
      rb_q    <= REG_NONE;
      valc_q  <= 64'd0;
      valp_q  <= RESET_PC;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      cidx_q  <= cidx_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = pc_q + ADDR_W'(idx_q);
  assign bus.out_valid = (state_q == OUT);
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.ra        = ra_q;
  assign bus.rb        = rb_q;
  assign bus.valC      = valc_q;
  assign bus.valP      = valp_q;
  assign bus.pc_out    = pc_q;
  assign bus.stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Bench for y86_fetch_unit: byte memory model, instruction-level reference, directed + random streams.
// Latency: n/a.
// Backpressure: randomised out_ready and mem_ack waits in the random phase.
module tb_y86_fetch_unit;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [1:0]  stat;
  } rec_t;

  logic clk;
  logic rst_n;
  bit   rnd_wait;
  int   n_chk, n_pass, taken;

  logic [7:0] mem  [bit [63:0]];
  bit         errs [bit [63:0]];

  y86_fetch_unit_if #(.ADDR_W(64)) bus ();

  y86_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory responder: answers at the falling edge, consumed at the next rising edge.
  always @(negedge clk) begin
    bus.mem_ack   = bus.mem_req && (!rnd_wait || ($urandom_range(0, 2) != 0));
    bus.mem_rdata = rd(bus.mem_addr);
    bus.mem_err   = bus.mem_ack && errs.exists(bus.mem_addr);
  end

  always @(posedge clk) if (rst_n && bus.mem_req && bus.mem_ack) taken = taken + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: parse one instruction at pc straight from the byte map using the ISA tables.
  function automatic rec_t model_fetch(input logic [63:0] pc);
    rec_t r; logic [7:0] b; int len; int maxf; bit hasreg, hasc, ra_used, rb_used;
    logic [63:0] a;
    r.pc = pc; r.icode = 4'h1; r.ifun = 4'h0; r.ra = 4'hF; r.rb = 4'hF;
    r.valc = 64'd0; r.stat = 2'd0; r.valp = pc;
    if (errs.exists(pc)) begin r.stat = 2'd2; return r; end
    b = rd(pc); r.icode = b[7:4]; r.ifun = b[3:0];
    case (r.icode)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h7, 4'h8:             len = 9;
      4'h3, 4'h4, 4'h5:       len = 10;
      default:                len = 0;
    endcase
    maxf = (r.icode == 4'h2 || r.icode == 4'h7) ? 6 : (r.icode == 4'h6) ? 3 : 0;
    if (len == 0 || int'(r.ifun) > maxf) begin r.stat = 2'd3; return r; end
    r.valp = pc + 64'(len);
    if (r.icode == 4'h0) begin r.stat = 2'd1; return r; end
    hasreg = (len == 2) || (len == 10);
    hasc   = (len >= 9);
    if (hasreg) begin
      if (errs.exists(pc + 64'd1)) begin r.stat = 2'd2; return r; end
      b = rd(pc + 64'd1); r.ra = b[7:4]; r.rb = b[3:0];
`ifdef STRICT_REG_CHECK_EN
      ra_used = (r.icode != 4'h3);
      rb_used = (r.icode != 4'hA) && (r.icode != 4'hB);
      if ((ra_used == (r.ra == 4'hF)) || (rb_used == (r.rb == 4'hF))) begin
        r.stat = 2'd3; return r;
      end
`else
      ra_used = 1'b0; rb_used = 1'b0;
`endif
    end
    if (hasc) begin
      for (int k = 0; k < 8; k++) begin
        a = pc + (hasreg ? 64'd2 : 64'd1) + 64'(k);
        if (errs.exists(a)) begin r.stat = 2'd2; return r; end
        r.valc[8*k +: 8] = rd(a);
      end
    end
    return r;
  endfunction

  task automatic cmp_fields(input string pfx, input rec_t e);
    chk({pfx, "_icode"}, 64'(bus.icode), 64'(e.icode));
    chk({pfx, "_ifun"},  64'(bus.ifun),  64'(e.ifun));
    chk({pfx, "_ra"},    64'(bus.ra),    64'(e.ra));
    chk({pfx, "_rb"},    64'(bus.rb),    64'(e.rb));
    chk({pfx, "_valC"},  bus.valC,       e.valc);
    chk({pfx, "_pc"},    bus.pc_out,     e.pc);
    chk({pfx, "_stat"},  64'(bus.stat),  64'(e.stat));
    if (e.stat <= 2'd1) chk({pfx, "_valP"}, bus.valP, e.valp);
  endtask

  // Follows the sequential stream from start, comparing each handshake with the model.
  task automatic run_stream(input logic [63:0] start, input bit rnd_ready);
    rec_t e; logic [63:0] pc; bit done, got;
    pc = start; done = 0; got = 0; e = model_fetch(start);
    for (int n = 0; n < 64 && !done; n++) begin
      e = model_fetch(pc);
      got = 0;
      for (int cyc = 0; cyc < 400 && !got; cyc++) begin
        @(negedge clk);
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_valid && bus.out_ready) got = 1;
      end
      if (!got) begin
        chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        done = 1;
      end else begin
        cmp_fields("instr", e);
        if (e.stat != 2'd0) done = 1; else pc = e.valp;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (got && e.stat != 2'd0) begin
      for (int i = 0; i < 5; i++) begin
        chk("stop_mem_req", 64'(bus.mem_req), 64'd0);
        chk("stop_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
      end
    end
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_addr(input logic [63:0] a);
    for (int i = 0; i < 200 && bus.mem_addr !== a; i++) @(negedge clk);
    chk("wait_addr", bus.mem_addr, a);
  endtask

  task automatic load(input logic [63:0] base, input logic [7:0] b [$]);
    foreach (b[i]) mem[base + 64'(i)] = b[i];
  endtask

  task automatic gen_prog(input logic [63:0] base, input int n);
    logic [3:0] codes [11];
    logic [63:0] a, c; logic [3:0] ic, fn, ra, rb; int maxf;
    codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    a = base;
    for (int i = 0; i < n; i++) begin
      ic   = codes[$urandom_range(0, 10)];
      maxf = (ic == 4'h2 || ic == 4'h7) ? 6 : (ic == 4'h6) ? 3 : 0;
      fn   = 4'($urandom_range(0, maxf));
      mem[a] = {ic, fn}; a = a + 64'd1;
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        ra = (ic == 4'h3) ? 4'hF : 4'($urandom_range(0, 14));
        rb = (ic == 4'hA || ic == 4'hB) ? 4'hF : 4'($urandom_range(0, 14));
        mem[a] = {ra, rb}; a = a + 64'd1;
      end
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
        c = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) begin mem[a] = c[8*k +: 8]; a = a + 64'd1; end
      end
    end
    mem[a] = 8'h00;
  endtask

  initial begin
    rec_t e; int cyc; int t0; logic [63:0] base;
    n_chk = 0; n_pass = 0; taken = 0; rnd_wait = 0;
    rst_n = 1'b1;
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 64'd0;
    #1 rst_n = 1'b0;

    // irmovq $10,%rdx at 0
    load(64'h0, '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_icode", 64'(bus.icode), 64'd1);
    chk("rst_ifun", 64'(bus.ifun), 64'd0);
    chk("rst_ra", 64'(bus.ra), 64'hF);
    chk("rst_rb", 64'(bus.rb), 64'hF);
    chk("rst_valC", bus.valC, 64'd0);
    chk("rst_valP", bus.valP, 64'd0);
    chk("rst_pc", bus.pc_out, 64'd0);
    chk("rst_stat", 64'(bus.stat), 64'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_rst", 64'(bus.mem_req), 64'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("irmovq_latency", 64'(cyc), 64'd10);
    e = model_fetch(64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      cmp_fields("hold", e);
    end
    run_stream(64'h0, 1'b0);

    // OPq rax,rcx ; nop ; halt
    mem.delete();
    load(64'h0, '{8'h60, 8'h01, 8'h10, 8'h00});
    redirect_to(64'h0);
    run_stream(64'h0, 1'b0);

    // Illegal icode and out-of-range ifun: one byte each
    mem.delete(); mem[64'h0] = 8'hC0;
    redirect_to(64'h0); t0 = taken;
    run_stream(64'h0, 1'b0);
    chk("bytes_C0", 64'(taken - t0), 64'd1);
    mem[64'h0] = 8'h27;
    redirect_to(64'h0); t0 = taken;
    run_stream(64'h0, 1'b0);
    chk("bytes_27", 64'(taken - t0), 64'd1);

    // call at 0x40 faulting on byte 3, then resume at 0x100
    mem.delete();
    load(64'h40, '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    errs[64'h43] = 1'b1;
    redirect_to(64'h40);
    run_stream(64'h40, 1'b0);
    load(64'h100, '{8'h10, 8'h00});
    redirect_to(64'h100);
    chk("resume_addr", bus.mem_addr, 64'h100);
    run_stream(64'h100, 1'b0);
    errs.delete();

    // Redirect colliding with a constant byte
    mem.delete();
    load(64'h0, '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    load(64'h200, '{8'h30, 8'hF3, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    redirect_to(64'h0);
    wait_addr(64'h4);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("redir_addr", bus.mem_addr, 64'h200);
    chk("redir_out_valid", 64'(bus.out_valid), 64'd0);
    run_stream(64'h200, 1'b0);

    // Reset in the middle of the constant
    redirect_to(64'h0);
    wait_addr(64'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_icode", 64'(bus.icode), 64'd1);
    chk("mid_rst_rb", 64'(bus.rb), 64'hF);
    chk("mid_rst_valC", bus.valC, 64'd0);
    chk("mid_rst_pc", bus.pc_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(64'h0, 1'b0);

    // rrmovq with rA=F: legal unless strict register checking is built in
    mem.delete();
    load(64'h0, '{8'h20, 8'hF1, 8'h00});
    redirect_to(64'h0);
    run_stream(64'h0, 1'b0);

    // Random programs across the top of the address space, random waits and backpressure
    rnd_wait = 1;
    for (int r = 0; r < 3; r++) begin
      mem.delete();
      base = 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(0, 63));
      gen_prog(base, 25);
      redirect_to(base);
      run_stream(base, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
